// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main control: Moore FSM decoding the IR opcode into datapath selects and enables.
// Optional MIPS_MC_MEM_WAIT_EN: memory states stall on mem_ready, with Mealy-gated side-effect enables.
module mips_mc_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       ext_op,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  // state    | meaning
  // RESET    | post-reset idle, all outputs 0
  // FETCH    | read instruction, load IR, PC += 4
  // DECODE   | precompute branch target into ALUOut
  // MEM_ADDR | effective address for lw/sw
  // MEM_RD   | data memory read into MDR
  // MEM_WB   | MDR -> rt
  // MEM_WR   | store B to memory
  // R_EXEC   | R-type ALU operation
  // R_WB     | ALUOut -> rd
  // BRANCH   | beq compare, conditional PC load
  // JUMP     | PC <- jump target
  // I_EXEC   | immediate ALU operation
  // I_WB     | ALUOut -> rt
  // ILLEGAL  | unsupported opcode, flag and refetch
  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_I_EXEC   = 4'd11,
    S_I_WB     = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  state_t state_q, state_d;
  logic   mem_rdy;

`ifdef MIPS_MC_MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d       = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = ALU_ADD;
    pc_source     = 2'b00;
    ext_op        = 1'b0;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;

    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = mem_rdy;
        pc_write  = mem_rdy;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        state_d   = mem_rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        ext_op    = 1'b1;
        case (opcode)
          OP_RTYPE:                        state_d = S_R_EXEC;
          OP_LW, OP_SW:                    state_d = S_MEM_ADDR;
          OP_BEQ:                          state_d = S_BRANCH;
          OP_J:                            state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_I_EXEC;
          default:                         state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_op    = 1'b1;
        state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = mem_rdy ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_rdy;
        state_d    = mem_rdy ? S_FETCH : S_MEM_WR;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (opcode)
          OP_SLTI: begin alu_op = ALU_SLT; ext_op = 1'b1; end
          OP_ANDI: begin alu_op = ALU_AND; ext_op = 1'b0; end
          OP_ORI:  begin alu_op = ALU_OR;  ext_op = 1'b0; end
          default: begin alu_op = ALU_ADD; ext_op = 1'b1; end
        endcase
        state_d = S_I_WB;
      end
      S_I_WB: begin
        // ext_op tracks the I_EXEC choice so the extender output stays stable through write-back
        reg_write  = 1'b1;
        instr_done = 1'b1;
        ext_op     = (opcode == OP_ADDI) || (opcode == OP_SLTI);
      end
      S_ILLEGAL: illegal_op = 1'b1;
      default:   state_d = S_FETCH;
    endcase
  end

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Main control unit for the multi-cycle MIPS datapath. The block decodes the opcode held in the instruction register and steps a Moore state machine through fetch, decode, execute, memory and write-back. Each cycle it drives the datapath select and enable lines: PC, instruction register, register file, ALU operand muxes, ALU operation and memory. It also drives `ext_op`, which selects between sign-extension and zero-extension in the immediate extender (`SignExtImm`).

## Interface
- No parameters.
- `clk`: input, 1 bit. Rising-edge clock.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `opcode`: input, 6 bits. Instruction bits [31:26] from the IR.
- `mem_ready`: input, 1 bit. Memory access complete. Used only with `MEM_WAIT_EN`.
- `pc_write`: output, 1 bit. Unconditional PC load.
- `pc_write_cond`: output, 1 bit. PC load if ALU zero.
- `i_or_d`: output, 1 bit. Memory address select: 0 = PC, 1 = ALUOut.
- `mem_read`: output, 1 bit. Memory read enable.
- `mem_write`: output, 1 bit. Memory write enable.
- `ir_write`: output, 1 bit. IR load enable.
- `mem_to_reg`: output, 1 bit. Write-back data select: 0 = ALUOut, 1 = MDR.
- `reg_dst`: output, 1 bit. Destination register select: 0 = rt, 1 = rd.
- `reg_write`: output, 1 bit. Register file write enable.
- `alu_src_a`: output, 1 bit. ALU A operand: 0 = PC, 1 = A.
- `alu_src_b`: output, 2 bits. ALU B operand: 00 = B, 01 = 4, 10 = ext imm, 11 = ext imm<<2.
- `alu_op`: output, 3 bits. 000 add, 001 sub, 010 funct-decoded, 011 and, 100 or, 101 slt.
- `pc_source`: output, 2 bits. PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ext_op`: output, 1 bit. Immediate extension: 1 = sign-extend, 0 = zero-extend.
- `instr_done`: output, 1 bit. One-cycle pulse on the last state of every instruction.
- `illegal_op`: output, 1 bit. One-cycle pulse on an unsupported opcode.
- `state`: output, 4 bits. Current state encoding, for debug.

## Operation
- States and encodings:
  - RESET = 0, FETCH = 1, DECODE = 2, MEM_ADDR = 3, MEM_RD = 4, MEM_WB = 5.
  - MEM_WR = 6, R_EXEC = 7, R_WB = 8, BRANCH = 9, JUMP = 10.
  - I_EXEC = 11, I_WB = 12, ILLEGAL = 13.
- RESET: all outputs 0. Advances to FETCH on the first clock edge with `rst_n` = 1.
- FETCH: `mem_read`, `ir_write`, `pc_write`; `alu_src_b` = 01; `alu_op` = add. Next state is DECODE.
- DECODE: `alu_src_b` = 11 with `ext_op` = 1, to precompute the branch target. Next state by opcode:
  - 000000 (R-type) → R_EXEC
  - 100011 (lw) and 101011 (sw) → MEM_ADDR
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - 001000 (addi), 001100 (andi), 001101 (ori), 001010 (slti) → I_EXEC
  - any other opcode → ILLEGAL
- MEM_ADDR: `alu_src_a` = 1, `alu_src_b` = 10, `ext_op` = 1, add. lw → MEM_RD; sw → MEM_WR.
- MEM_RD: `mem_read`, `i_or_d` = 1. Next state is MEM_WB.
- MEM_WB: `reg_write`, `mem_to_reg` = 1, `reg_dst` = 0, `instr_done`. Next state is FETCH.
- MEM_WR: `mem_write`, `i_or_d` = 1, `instr_done`. Next state is FETCH.
- R_EXEC: `alu_src_a` = 1, `alu_src_b` = 00, `alu_op` = 010. Next state is R_WB.
- R_WB: `reg_write`, `reg_dst` = 1, `instr_done`. Next state is FETCH.
- BRANCH: `alu_src_a` = 1, `alu_src_b` = 00, sub, `pc_write_cond`, `pc_source` = 01, `instr_done`. Next state is FETCH.
- JUMP: `pc_write`, `pc_source` = 10, `instr_done`. Next state is FETCH.
- I_EXEC: `alu_src_a` = 1, `alu_src_b` = 10. Operation and extension by opcode:
  - addi: add, `ext_op` = 1
  - slti: slt, `ext_op` = 1
  - andi: and, `ext_op` = 0
  - ori: or, `ext_op` = 0
  - Next state is I_WB.
- I_WB: `reg_write`, `reg_dst` = 0, `mem_to_reg` = 0, `instr_done`. `ext_op` holds the I_EXEC value. Next state is FETCH.
- ILLEGAL: `illegal_op` = 1. No write enables asserted. Next state is FETCH; the PC was already advanced in FETCH.
- Any output not listed for a state is 0.
- `opcode` is sampled only in DECODE, MEM_ADDR, I_EXEC and I_WB. The IR is stable during these states because `ir_write` is asserted only in FETCH.

## Timing
- Outputs are decoded combinationally from the state register.
- The one exception is the Mealy gating of memory-state enables under `MEM_WAIT_EN`.
- `rst_n` low forces RESET immediately, including mid-instruction. Partially executed instructions are dropped.
- Cycles per instruction without waits:
  - lw: 5
  - sw, R-type, I-type: 4
  - beq, j: 3
  - illegal: 3
- An unknown state encoding (14, 15) goes to FETCH on the next edge, with all outputs 0 in that cycle.

## Configuration
- `MIPS_MC_MEM_WAIT_EN` defined:
  - FETCH, MEM_RD and MEM_WR hold while `mem_ready` = 0.
  - `mem_read` / `mem_write` stay asserted while held.
  - `ir_write` and `pc_write` (FETCH) and `instr_done` (MEM_WR) assert only in the cycle `mem_ready` = 1.
  - The state advances on that edge.
- Not defined: `mem_ready` is ignored and every memory state lasts exactly one cycle.

## Test plan
- Reset, then lw (opcode 100011): RESET → FETCH → DECODE → MEM_ADDR → MEM_RD → MEM_WB. `reg_write` = 1 and `mem_to_reg` = 1 in cycle 5; `instr_done` pulses once.
- andi (001100) → I_EXEC drives `ext_op` = 0 and `alu_op` = 011. addi (001000) → `ext_op` = 1 and `alu_op` = 000. Both reach I_WB with `reg_dst` = 0.
- beq (000100) → BRANCH with `pc_write_cond` = 1, `pc_source` = 01, `alu_op` = 001, then FETCH; 3 cycles total.
- Opcode 111111 → ILLEGAL with `illegal_op` pulsing once and no writes asserted, then FETCH.
- Assert `rst_n` = 0 during MEM_WR: `mem_write` drops to 0 immediately and `state` = 0 without waiting for a clock edge.
- With `MIPS_MC_MEM_WAIT_EN`, hold `mem_ready` = 0 for 3 cycles in FETCH: `mem_read` stays 1 and `ir_write` stays 0. `ir_write` = 1 only in the cycle `mem_ready` = 1, followed by DECODE.
